// File: rtl/ddr3_chk_pkg.sv
// Shared types and constants for the DDR3 pattern writer/checker.
// Holds the FSM states, pattern mode encodings and the PRBS16 definition.
package ddr3_chk_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWaitRd,
        StRead,
        StDrain,
        StDone
    } chk_state_e;

    localparam logic MODE_CNT  = 1'b0;
    localparam logic MODE_PRBS = 1'b1;

    // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci LFSR: feedback from bits 0,2,3,5
    localparam logic [15:0] PRBS_TAPS    = 16'h002D;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    function automatic logic [15:0] prbs16_next(input logic [15:0] s);
        return {^(s & PRBS_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/ddr3_pat_gen.sv
// Pattern word generator: incrementing counter or PRBS16, reloaded per frame.
// Two instances (write side and read side) produce identical sequences.
module ddr3_pat_gen import ddr3_chk_pkg::*; #(
    parameter int unsigned DATA_W = 16,
    parameter logic [15:0] SEED   = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] seed,
    input  logic              mode,
    input  logic              adv,
    output logic [DATA_W-1:0] word
);

    logic [DATA_W-1:0] cnt_q;
    logic [15:0]       lfsr_q;
    logic [15:0]       lfsr_seed;

    // An all-zero LFSR would lock up, so fall back to the default seed
    assign lfsr_seed = (16'(seed) == 16'h0000) ? SEED : 16'(seed);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q  <= '0;
            lfsr_q <= SEED;
        end else if (load) begin
            cnt_q  <= seed;
            lfsr_q <= lfsr_seed;
        end else if (adv) begin
            cnt_q  <= cnt_q + DATA_W'(1);
            lfsr_q <= prbs16_next(lfsr_q);
        end
    end

    assign word = (mode == MODE_PRBS) ? DATA_W'(lfsr_q) : cnt_q;

endmodule

// File: rtl/ddr3_pattern_checker.sv
// DDR3 test traffic source and read-back checker on the user side of the controller FIFOs.
// Writes a frame of pattern words, reads it back, compares and keeps sticky status.
module ddr3_pattern_checker import ddr3_chk_pkg::*; #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned FRAME_WORDS = 1024,
    parameter int unsigned TIMEOUT     = 2**20,
    parameter logic [15:0] SEED        = DEFAULT_SEED
) (
    input  logic              clk_50m,
    input  logic              rst,
    input  logic              init_calib_complete,
    input  logic              mode,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    input  logic              rd_valid,
    output logic              rd_req,
    input  logic [DATA_W-1:0] rd_data,
    output logic              error,
    output logic              timeout,
    output logic [15:0]       pass_cnt,
    output logic [15:0]       err_cnt,
    output logic [15:0]       first_err_idx,
    output logic              busy
);

    localparam int unsigned IDX_W = $clog2(FRAME_WORDS);
    localparam int unsigned TMO_W = $clog2(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_WORDS - 1);
    localparam logic [TMO_W-1:0] LAST_TMO = TMO_W'(TIMEOUT - 1);

    chk_state_e        state_q;
    logic              calib_meta;
    logic              calib_s;
    logic              mode_q;
    logic [IDX_W-1:0]  wr_idx_q;
    logic [IDX_W-1:0]  rd_idx_q;
    logic [IDX_W-1:0]  cmp_idx_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [DATA_W-1:0] frame_no_q;
    logic [15:0]       prbs_seed_q;
    logic              frame_err_q;
    logic              rd_req_d1;
    logic [DATA_W-1:0] exp_q;

    logic              gen_load;
    logic [DATA_W-1:0] gen_seed;
    logic [DATA_W-1:0] wr_word;
    logic [DATA_W-1:0] rd_word;
    logic [15:0]       wr_end_state;

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            calib_meta <= 1'b0;
            calib_s    <= 1'b0;
        end else begin
            calib_meta <= init_calib_complete;
            calib_s    <= calib_meta;
        end
    end

    assign gen_load = (state_q == StIdle) && calib_s;
    // Mode is sampled from the live input on the load cycle, before mode_q catches up
    assign gen_seed = (mode == MODE_PRBS) ? DATA_W'(prbs_seed_q) : frame_no_q;

    assign wr_en   = (state_q == StWrite) && wr_ready;
    assign wr_data = (state_q == StWrite) ? wr_word : '0;
    assign rd_req  = (state_q == StRead) && rd_valid;
    assign busy    = (state_q != StIdle);

    // In PRBS mode the write word is the LFSR state, so it doubles as the next frame seed
    assign wr_end_state = 16'(wr_word);

    ddr3_pat_gen #(
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_wr_gen (
        .clk  (clk_50m),
        .rst  (rst),
        .load (gen_load),
        .seed (gen_seed),
        .mode (mode_q),
        .adv  (wr_en),
        .word (wr_word)
    );

    ddr3_pat_gen #(
        .DATA_W (DATA_W),
        .SEED   (SEED)
    ) u_rd_gen (
        .clk  (clk_50m),
        .rst  (rst),
        .load (gen_load),
        .seed (gen_seed),
        .mode (mode_q),
        .adv  (rd_req),
        .word (rd_word)
    );

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            mode_q        <= MODE_CNT;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            cmp_idx_q     <= '0;
            tmo_q         <= '0;
            frame_no_q    <= '0;
            prbs_seed_q   <= SEED;
            frame_err_q   <= 1'b0;
            rd_req_d1     <= 1'b0;
            exp_q         <= '0;
            error         <= 1'b0;
            timeout       <= 1'b0;
            pass_cnt      <= '0;
            err_cnt       <= '0;
            first_err_idx <= '0;
        end else begin
            rd_req_d1 <= rd_req;
            if (rd_req) begin
                exp_q     <= rd_word;
                cmp_idx_q <= rd_idx_q;
            end

            if (rd_req_d1 && (rd_data != exp_q)) begin
                error       <= 1'b1;
                frame_err_q <= 1'b1;
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
                if (!error) begin
                    first_err_idx <= 16'(cmp_idx_q);
                end
            end

            if ((state_q != StIdle) && !calib_s) begin
                state_q <= StIdle;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (calib_s) begin
                            state_q     <= StWrite;
                            mode_q      <= mode;
                            wr_idx_q    <= '0;
                            rd_idx_q    <= '0;
                            frame_err_q <= 1'b0;
                        end
                    end
                    StWrite: begin
                        if (wr_en) begin
                            wr_idx_q <= wr_idx_q + IDX_W'(1);
                            if (wr_idx_q == LAST_IDX) begin
                                state_q <= StWaitRd;
                                tmo_q   <= '0;
                            end
                        end
                    end
                    StWaitRd: begin
                        if (rd_valid) begin
                            state_q <= StRead;
                        end else if (tmo_q == LAST_TMO) begin
                            timeout <= 1'b1;
                            error   <= 1'b1;
                            state_q <= StIdle;
                        end else begin
                            tmo_q <= tmo_q + TMO_W'(1);
                        end
                    end
                    StRead: begin
                        if (rd_req) begin
                            rd_idx_q <= rd_idx_q + IDX_W'(1);
                            if (rd_idx_q == LAST_IDX) begin
                                state_q <= StDrain;
                            end
                        end
                    end
                    StDrain: begin
                        state_q <= StDone;
                    end
                    StDone: begin
                        if (!frame_err_q && (pass_cnt != 16'hFFFF)) begin
                            pass_cnt <= pass_cnt + 16'd1;
                        end
                        frame_no_q <= frame_no_q + DATA_W'(1);
                        if (mode_q == MODE_PRBS) begin
                            prbs_seed_q <= (wr_end_state == 16'h0000) ? SEED : wr_end_state;
                        end
                        state_q <= StIdle;
                    end
                    default: begin
                        state_q <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ddr3_pattern_checker.sv
// Bench for ddr3_pattern_checker: loopback FIFO model, table of frame scenarios,
// plus timeout, calibration-drop and asynchronous reset sequences.
module tb_ddr3_pattern_checker;

    localparam int unsigned FW  = 8;
    localparam int unsigned TMO = 64;

    logic        clk_50m = 1'b0;
    logic        rst;
    logic        init_calib_complete;
    logic        mode;
    logic        wr_ready;
    logic        wr_en;
    logic [15:0] wr_data;
    logic        rd_valid;
    logic        rd_req;
    logic [15:0] rd_data;
    logic        error;
    logic        timeout;
    logic [15:0] pass_cnt;
    logic [15:0] err_cnt;
    logic [15:0] first_err_idx;
    logic        busy;

    always #5 clk_50m = ~clk_50m;

    ddr3_pattern_checker #(
        .DATA_W      (16),
        .FRAME_WORDS (FW),
        .TIMEOUT     (TMO),
        .SEED        (16'hACE1)
    ) dut (
        .clk_50m             (clk_50m),
        .rst                 (rst),
        .init_calib_complete (init_calib_complete),
        .mode                (mode),
        .wr_ready            (wr_ready),
        .wr_en               (wr_en),
        .wr_data             (wr_data),
        .rd_valid            (rd_valid),
        .rd_req              (rd_req),
        .rd_data             (rd_data),
        .error               (error),
        .timeout             (timeout),
        .pass_cnt            (pass_cnt),
        .err_cnt             (err_cnt),
        .first_err_idx       (first_err_idx),
        .busy                (busy)
    );

    // One scenario: inputs (mode, frames, corrupted word, stalls, gaps) and expected status after it
    typedef struct {
        logic        md;
        int          nfr;
        int          corrupt;
        logic        stall;
        logic        gaps;
        logic [15:0] pass;
        logic [15:0] errs;
        logic [15:0] fidx;
        logic        err;
        logic        tmo;
    } vec_t;

    vec_t        tbl[6];
    int          vectors = 0;
    int          fails = 0;
    logic [15:0] fifo[$];
    logic [15:0] exp_q[$];
    logic [15:0] wr_log[$];
    int          pushes, pops, corrupt_at, first_wr;
    logic        stall, gaps, no_rd;
    int          m_frame;
    logic [15:0] m_seed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
    endfunction

    // Expected write stream for nfr frames, advancing the model's frame number and seed
    task automatic build(input logic md, input int nfr);
        logic [15:0] s;
        exp_q.delete();
        for (int f = 0; f < nfr; f++) begin
            s = m_seed;
            for (int k = 0; k < int'(FW); k++) begin
                if (md) begin
                    exp_q.push_back(s);
                    s = lfsr_step(s);
                end else begin
                    exp_q.push_back(16'(k + m_frame));
                end
            end
            if (md) m_seed = (s == 16'h0000) ? 16'hACE1 : s;
            m_frame++;
        end
    endtask

    // Entered and left at 2 time units after a rising edge
    task automatic step();
        logic        push, pop;
        logic [15:0] wd;
        push = wr_en;
        pop  = rd_req;
        wd   = wr_data;
        @(posedge clk_50m);
        #1;
        if (push) begin
            if (pushes < exp_q.size()) chk("wr_data", 32'(wd), 32'(exp_q[pushes]));
            wr_log.push_back(wd);
            fifo.push_back((pushes == corrupt_at) ? (wd ^ 16'h0001) : wd);
            pushes++;
        end
        if (pop) begin
            if (fifo.size() == 0) begin
                fails++;
                $display("FAIL fifo_underflow: got pop with 0 words stored, expected at least 1");
            end else begin
                rd_data = fifo.pop_front();
            end
            pops++;
        end
        wr_ready = stall ? ~wr_ready : 1'b1;
        rd_valid = !no_rd && (fifo.size() > 0) && (!gaps || ($urandom_range(0, 2) != 0));
        #1;
    endtask

    task automatic run_row(input vec_t v, input int row);
        int cyc, target;
        build(v.md, v.nfr);
        wr_log.delete();
        mode       = v.md;
        stall      = v.stall;
        gaps       = v.gaps;
        corrupt_at = v.corrupt;
        no_rd      = 1'b0;
        pushes     = 0;
        pops       = 0;
        first_wr   = 0;
        wr_ready   = 1'b1;
        rd_valid   = 1'b0;
        init_calib_complete = 1'b1;
        #1;
        target = v.nfr * int'(FW);
        cyc    = 0;
        while (pops < target && cyc < target * 10 + 100) begin
            step();
            cyc++;
            if (first_wr == 0 && wr_en) first_wr = cyc;
            if (pops == target) init_calib_complete = 1'b0;
        end
        if (pops < target) begin
            fails++;
            $display("FAIL row%0d_budget: got %0d pops, expected %0d", row, pops, target);
        end
        init_calib_complete = 1'b0;
        repeat (6) step();
        if (row == 0) begin
            chk("start_latency", 32'(first_wr), 32'd3);
            chk("cnt_frame1_first", 32'(wr_log[FW]), 32'd1);
            chk("cnt_frame1_last", 32'(wr_log[2*FW-1]), 32'd8);
        end
        if (row == 1) begin
            chk("prbs_word0", 32'(wr_log[0]), 32'h0000ACE1);
            chk("prbs_word1", 32'(wr_log[1]), 32'h00005670);
        end
        chk($sformatf("row%0d_push_count", row), 32'(pushes), 32'(target));
        chk($sformatf("row%0d_busy", row), 32'(busy), 32'd0);
        chk($sformatf("row%0d_pass_cnt", row), 32'(pass_cnt), 32'(v.pass));
        chk($sformatf("row%0d_err_cnt", row), 32'(err_cnt), 32'(v.errs));
        chk($sformatf("row%0d_first_err_idx", row), 32'(first_err_idx), 32'(v.fidx));
        chk($sformatf("row%0d_error", row), 32'(error), 32'(v.err));
        chk($sformatf("row%0d_timeout", row), 32'(timeout), 32'(v.tmo));
        fifo.delete();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "wr_en"}, 32'(wr_en), 32'd0);
        chk({tag, "rd_req"}, 32'(rd_req), 32'd0);
        chk({tag, "wr_data"}, 32'(wr_data), 32'd0);
        chk({tag, "error"}, 32'(error), 32'd0);
        chk({tag, "timeout"}, 32'(timeout), 32'd0);
        chk({tag, "pass_cnt"}, 32'(pass_cnt), 32'd0);
        chk({tag, "err_cnt"}, 32'(err_cnt), 32'd0);
        chk({tag, "first_err_idx"}, 32'(first_err_idx), 32'd0);
        chk({tag, "busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int          cyc;
        int          save_frame;
        logic [15:0] save_seed;

        tbl[0] = '{1'b0, 3, -1, 1'b0, 1'b0, 16'd3,  16'd0, 16'd0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 2, -1, 1'b0, 1'b0, 16'd5,  16'd0, 16'd0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 3,  5, 1'b0, 1'b0, 16'd7,  16'd1, 16'd5, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 3, -1, 1'b1, 1'b1, 16'd10, 16'd1, 16'd5, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 1, -1, 1'b0, 1'b0, 16'd11, 16'd1, 16'd5, 1'b1, 1'b1};
        tbl[5] = '{1'b0, 2, -1, 1'b0, 1'b1, 16'd2,  16'd0, 16'd0, 1'b0, 1'b0};

        rst = 1'b1;
        init_calib_complete = 1'b0;
        mode = 1'b0;
        wr_ready = 1'b0;
        rd_valid = 1'b0;
        rd_data = 16'h0000;
        stall = 1'b0;
        gaps = 1'b0;
        no_rd = 1'b0;
        corrupt_at = -1;
        pushes = 0;
        pops = 0;
        m_frame = 0;
        m_seed = 16'hACE1;

        #3;
        check_reset("por_");
        @(posedge clk_50m);
        @(posedge clk_50m);
        #2;
        rst = 1'b0;

        for (int i = 0; i < 4; i++) run_row(tbl[i], i);

        // Read side never responds: timeout exactly TMO cycles after entering WAIT_RD
        save_frame = m_frame;
        save_seed  = m_seed;
        build(1'b0, 1);
        m_frame = save_frame;
        m_seed  = save_seed;
        mode = 1'b0; stall = 1'b0; gaps = 1'b0; no_rd = 1'b1; corrupt_at = -1;
        pushes = 0; pops = 0; wr_ready = 1'b1; rd_valid = 1'b0;
        init_calib_complete = 1'b1;
        #1;
        cyc = 0;
        while (pushes < int'(FW) && cyc < 100) begin
            step();
            cyc++;
        end
        if (pushes < int'(FW)) begin
            fails++;
            $display("FAIL tmo_write_budget: got %0d pushes, expected %0d", pushes, FW);
        end
        repeat (TMO - 1) step();
        chk("tmo_before", 32'(timeout), 32'd0);
        chk("tmo_busy_before", 32'(busy), 32'd1);
        step();
        chk("tmo_flag", 32'(timeout), 32'd1);
        chk("tmo_error", 32'(error), 32'd1);
        chk("tmo_idle", 32'(busy), 32'd0);
        init_calib_complete = 1'b0;
        repeat (6) step();
        fifo.delete();
        exp_q.delete();
        no_rd = 1'b0;

        // Calibration lost mid-WRITE: abort, then the next frame reuses the same seed
        mode = 1'b1; pushes = 0; pops = 0; wr_ready = 1'b1; rd_valid = 1'b0;
        init_calib_complete = 1'b1;
        #1;
        cyc = 0;
        while (pushes < 3 && cyc < 50) begin
            step();
            cyc++;
        end
        init_calib_complete = 1'b0;
        cyc = 0;
        while (busy && cyc < 10) begin
            step();
            cyc++;
        end
        chk("abort_within_3", 32'(cyc <= 3), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (4) step();
        fifo.delete();
        run_row(tbl[4], 4);

        // Asynchronous reset in the middle of READ
        build(1'b0, 1);
        mode = 1'b0; stall = 1'b0; gaps = 1'b0; no_rd = 1'b0; corrupt_at = -1;
        pushes = 0; pops = 0; wr_ready = 1'b1; rd_valid = 1'b0;
        init_calib_complete = 1'b1;
        #1;
        cyc = 0;
        while (pops < 3 && cyc < 100) begin
            step();
            cyc++;
        end
        chk("rst_pre_busy", 32'(busy), 32'd1);
        chk("rst_pre_rd_req", 32'(rd_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset("rst_async_");
        init_calib_complete = 1'b0;
        wr_ready = 1'b0;
        rd_valid = 1'b0;
        @(posedge clk_50m);
        #2;
        rst = 1'b0;
        repeat (4) step();
        fifo.delete();
        m_frame = 0;
        m_seed  = 16'hACE1;
        run_row(tbl[5], 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule

// File: doc/ddr3_pattern_checker.md
# ddr3_pattern_checker

Traffic source and read-back checker for the DDR3 read/write test top. It sits on the user side of the DDR3 controller's write/read FIFOs in the 50 MHz domain. It writes frames of deterministic pattern words, then reads the same number of words back and compares them against a regenerated copy of the pattern. It reports sticky error status, counters and the first failing index to the LED display and ILA.

## Interface
Parameters:
- DATA_W, 16, FIFO data width.
- FRAME_WORDS, 1024, words per write/read frame; at least 2.
- TIMEOUT, 2^20, cycles allowed in WAIT_RD before a timeout error.
- SEED, 16'hACE1, initial PRBS seed; must be non-zero.

Ports:
- clk_50m  input  1  user clock; all logic is in this single domain.
- rst  input  1  reset; asynchronous, active-high.
- init_calib_complete  input  1  DDR3 calibration done; arrives asynchronously.
- mode  input  1  pattern select: 0 = incrementing counter, 1 = PRBS16. Sampled at frame start.
- wr_ready  input  1  write FIFO can accept a word this cycle.
- wr_en  output  1  write strobe.
- wr_data  output  DATA_W  write word; valid while wr_en is high.
- rd_valid  input  1  read FIFO is non-empty.
- rd_req  output  1  read FIFO pop.
- rd_data  input  DATA_W  read word; valid 1 cycle after rd_req.
- error  output  1  sticky: any mismatch or timeout.
- timeout  output  1  sticky: WAIT_RD timeout.
- pass_cnt  output  16  frames that completed with no mismatch; saturates at 16'hFFFF.
- err_cnt  output  16  mismatched words; saturates at 16'hFFFF.
- first_err_idx  output  16  word index of the first mismatch since reset.
- busy  output  1  high in any state other than IDLE.

## Operation
- init_calib_complete passes through a 2-flop synchronizer to give calib_s.
- States and transitions:
  - IDLE -> WRITE when calib_s = 1. On this transition, latch mode and load both generators with the frame seed.
  - WRITE: wr_en = wr_ready. Each accepted word advances the write generator and wr_idx. After word FRAME_WORDS-1 is accepted, go to WAIT_RD.
  - WAIT_RD -> READ when rd_valid = 1. If the timeout counter reaches TIMEOUT-1 first, set timeout and error, then go to IDLE.
  - READ: rd_req = rd_valid. After FRAME_WORDS pops, go to DRAIN.
  - DRAIN: wait 1 cycle for the last compare, then go to DONE.
  - DONE: increment pass_cnt if frame_err = 0, advance the frame seed, return to IDLE. IDLE restarts immediately if calib_s is still high.
- Pattern generation:
  - Counter mode: word k = k + frame_no, truncated to DATA_W.
  - PRBS16: Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1, shifting once per word. The seed for frame n is the LFSR state at the end of frame n-1; a seed of zero is replaced by SEED.
- Compare: on rd_req_d1, compare rd_data against the expected word from the read generator. The read generator advances on rd_req.
  - On mismatch: set error and frame_err, increment err_cnt (saturating). Capture first_err_idx only while error was still 0.
- If calib_s falls in any state other than IDLE, abort to IDLE. Generators are reset; counters and sticky flags are kept.
- Sticky flags and counters clear only on rst.

## Timing
- Reset values: wr_en = 0, rd_req = 0, wr_data = 0, error = 0, timeout = 0, pass_cnt = 0, err_cnt = 0, first_err_idx = 0, busy = 0; state = IDLE.
- Start latency: init_calib_complete rising -> first possible wr_en is 3 cycles later (2 synchronizer stages + IDLE->WRITE).
- wr_en and wr_data are combinational from the state and registered generator output. wr_ready low stalls with wr_data held.
- Read-to-compare latency is 1 cycle. The error flag rises 2 cycles after the rd_req that popped the bad word.
- Simultaneous last write accept and rd_valid high: the frame still enters WAIT_RD first; no READ before WAIT_RD.
- The WAIT_RD timeout counter resets on WAIT_RD entry.

## Structure
- Package ddr3_chk_pkg holds:
  - the state enum (IDLE, WRITE, WAIT_RD, READ, DRAIN, DONE);
  - MODE_CNT and MODE_PRBS;
  - PRBS16 taps and the default seed.
- Sub-module ddr3_pat_gen (load, seed, mode, adv -> word) is instantiated twice, as the write and read generators, so that both produce identical sequences.

## Test plan
- Loopback FIFO model, mode 0, FRAME_WORDS = 8: after 3 frames, pass_cnt = 3 and error = 0. Frame 1 writes 1..8.
- Mode 1, SEED = 16'hACE1: first wr_data = 16'hACE1 and the second word matches the reference LFSR step. 2 frames pass.
- Model corrupts word 5 of frame 0 (XOR 16'h0001): error = 1, err_cnt = 1, first_err_idx = 5. pass_cnt stays 0, then increments for the following clean frames.
- Model never asserts rd_valid, TIMEOUT = 64: timeout = 1 and error = 1 exactly 64 cycles after WAIT_RD entry; state returns to IDLE.
- wr_ready toggles 1010 and rd_valid has random gaps: no lost or duplicated words, and all frames pass.
- calib drop mid-WRITE, then re-assert: busy = 0 within 3 cycles of the drop, and the next frame restarts from the seed and passes. An rst pulse mid-READ drives all outputs to their reset values asynchronously.
